// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the operand forwarding unit.
//   - SRC_* : 2-bit codes reported on opnd_src (where an operand came from)
//   - fwd_state_t : interlock FSM state encoding
// -----------------------------------------------------------------------------
package fwd_pkg;

   localparam logic [1:0] SRC_RF  = 2'd0;
   localparam logic [1:0] SRC_EX  = 2'd1;
   localparam logic [1:0] SRC_MEM = 2'd2;
   localparam logic [1:0] SRC_WB  = 2'd3;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } fwd_state_t;

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Purely combinational forwarding selector for one source operand.
// Finds the youngest in-flight producer of rs_addr (EX > MEM > WB) and
// returns its value, or the register-file value if none matches.
// Ports:
//   id_valid, rs_used, rs_addr, rs_data : ID-stage operand request
//   ex_* / mem_* / wb_*                 : pipeline stage attributes/results
//   fwd_data : resolved operand value
//   fwd_src  : SRC_RF / SRC_EX / SRC_MEM / SRC_WB
//   load_use : operand depends on a load still in EX (cannot forward)
// -----------------------------------------------------------------------------
module fwd_select
   import fwd_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              id_valid,
   input  logic              rs_used,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [XLEN-1:0]   rs_data,
   input  logic              ex_valid,
   input  logic              ex_wen,
   input  logic              ex_is_load,
   input  logic              ex_is_link,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [XLEN-1:0]   ex_alu,
   input  logic [XLEN-1:0]   ex_pc4,
   input  logic              mem_valid,
   input  logic              mem_wen,
   input  logic              mem_is_load,
   input  logic              mem_is_link,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_alu,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic [XLEN-1:0]   mem_pc4,
   input  logic              wb_valid,
   input  logic              wb_wen,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   fwd_data,
   output logic [1:0]        fwd_src,
   output logic              load_use
);

   // x0 is excluded here once; a stage rd equal to a non-zero rs is then
   // non-zero too, so the per-stage checks need no separate rd != 0 term.
   logic rs_live;
   logic ex_hit;
   logic mem_hit;
   logic wb_hit;

   assign rs_live = id_valid & rs_used & (rs_addr != '0);
   assign ex_hit  = rs_live & ex_valid  & ex_wen  & (ex_rd  == rs_addr);
   assign mem_hit = rs_live & mem_valid & mem_wen & (mem_rd == rs_addr);
   assign wb_hit  = rs_live & wb_valid  & wb_wen  & (wb_rd  == rs_addr);

   always_comb begin
      fwd_data = rs_data;
      fwd_src  = SRC_RF;
      load_use = 1'b0;
      if (ex_hit) begin
         // A load in EX has no data yet; flag it so the top stalls instead.
         fwd_src  = SRC_EX;
         fwd_data = ex_is_link ? ex_pc4 : ex_alu;
         load_use = ex_is_load;
      end else if (mem_hit) begin
         fwd_src  = SRC_MEM;
         fwd_data = mem_is_load ? mem_rdata : (mem_is_link ? mem_pc4 : mem_alu);
      end else if (wb_hit) begin
         fwd_src  = SRC_WB;
         fwd_data = wb_data;
      end
   end

endmodule

// File: rtl/operand_forward_unit.sv
// -----------------------------------------------------------------------------
// operand_forward_unit
// Operand forwarding and load-use interlock at the ID/EX boundary.
// Each of NSRC register-file operands is replaced by the youngest in-flight
// result (EX > MEM > WB) and registered into EX. A consumer of a load still
// in EX stalls the front end for exactly LOAD_LAT cycles.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : redirect; kills the ID instruction, cancels stalls
//   id_valid/id_rs_*    : ID operand requests (operand i at slice i)
//   ex_*/mem_*/wb_*     : pipeline stage producers
//   stall               : combinational hold of PC and IF/ID
//   opnd/opnd_src       : registered resolved operands and their sources
//   opnd_valid          : registered EX valid (0 = bubble)
// -----------------------------------------------------------------------------
module operand_forward_unit
   import fwd_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NSRC     = 2,
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   id_valid,
   input  logic [NSRC*REG_AW-1:0] id_rs_addr,
   input  logic [NSRC-1:0]        id_rs_used,
   input  logic [NSRC*XLEN-1:0]   id_rs_data,
   input  logic                   ex_valid,
   input  logic                   ex_wen,
   input  logic                   ex_is_load,
   input  logic                   ex_is_link,
   input  logic [REG_AW-1:0]      ex_rd,
   input  logic [XLEN-1:0]        ex_alu,
   input  logic [XLEN-1:0]        ex_pc4,
   input  logic                   mem_valid,
   input  logic                   mem_wen,
   input  logic                   mem_is_load,
   input  logic                   mem_is_link,
   input  logic [REG_AW-1:0]      mem_rd,
   input  logic [XLEN-1:0]        mem_alu,
   input  logic [XLEN-1:0]        mem_rdata,
   input  logic [XLEN-1:0]        mem_pc4,
   input  logic                   wb_valid,
   input  logic                   wb_wen,
   input  logic [REG_AW-1:0]      wb_rd,
   input  logic [XLEN-1:0]        wb_data,
   output logic                   stall,
   output logic [NSRC*XLEN-1:0]   opnd,
   output logic [NSRC*2-1:0]      opnd_src,
   output logic                   opnd_valid
);

   // Counter must be at least one bit wide even when LOAD_LAT is 1.
   localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

   logic [NSRC*XLEN-1:0] res_opnd;
   logic [NSRC*2-1:0]    res_src;
   logic [NSRC-1:0]      res_lu;
   logic                 hz;

   fwd_state_t           state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [NSRC*XLEN-1:0] opnd_reg;
   logic [NSRC*2-1:0]    opnd_src_reg;
   logic                 opnd_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_sel
         fwd_select #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
         ) u_sel (
            .id_valid    (id_valid),
            .rs_used     (id_rs_used[gi]),
            .rs_addr     (id_rs_addr[gi*REG_AW +: REG_AW]),
            .rs_data     (id_rs_data[gi*XLEN +: XLEN]),
            .ex_valid    (ex_valid),
            .ex_wen      (ex_wen),
            .ex_is_load  (ex_is_load),
            .ex_is_link  (ex_is_link),
            .ex_rd       (ex_rd),
            .ex_alu      (ex_alu),
            .ex_pc4      (ex_pc4),
            .mem_valid   (mem_valid),
            .mem_wen     (mem_wen),
            .mem_is_load (mem_is_load),
            .mem_is_link (mem_is_link),
            .mem_rd      (mem_rd),
            .mem_alu     (mem_alu),
            .mem_rdata   (mem_rdata),
            .mem_pc4     (mem_pc4),
            .wb_valid    (wb_valid),
            .wb_wen      (wb_wen),
            .wb_rd       (wb_rd),
            .wb_data     (wb_data),
            .fwd_data    (res_opnd[gi*XLEN +: XLEN]),
            .fwd_src     (res_src[gi*2 +: 2]),
            .load_use    (res_lu[gi])
         );
      end
   endgenerate

   assign hz = |res_lu;

   // Hazards only start a stall from RUN; once in STALL the counter alone
   // decides when to release. flush and reset both override.
   assign stall = ~reset & ~flush &
                  ((state_reg == ST_STALL) | ((state_reg == ST_RUN) & hz));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_RUN;
         cnt_reg        <= '0;
         opnd_reg       <= '0;
         opnd_src_reg   <= '0;
         opnd_valid_reg <= 1'b0;
      end else if (flush) begin
         state_reg      <= ST_RUN;
         cnt_reg        <= '0;
         opnd_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_RUN: begin
               if (hz) begin
                  // First stall cycle is this one; STALL covers the rest.
                  opnd_valid_reg <= 1'b0;
                  if (LOAD_LAT > 1) begin
                     state_reg <= ST_STALL;
                     cnt_reg   <= CNT_W'(LOAD_LAT - 2);
                  end
               end else begin
                  opnd_reg       <= res_opnd;
                  opnd_src_reg   <= res_src;
                  opnd_valid_reg <= id_valid;
               end
            end
            ST_STALL: begin
               opnd_valid_reg <= 1'b0;
               if (cnt_reg == '0) begin
                  state_reg <= ST_RUN;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               state_reg      <= ST_RUN;
               cnt_reg        <= '0;
               opnd_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign opnd       = opnd_reg;
   assign opnd_src   = opnd_src_reg;
   assign opnd_valid = opnd_valid_reg;

endmodule

// File: tb/tb_operand_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_operand_forward_unit
// Drives two instances (LOAD_LAT=1 and LOAD_LAT=3) with identical stimulus:
// directed scenarios first, then random traffic, all compared against a
// stage-priority reference model that tracks remaining stall cycles.
// -----------------------------------------------------------------------------
module tb_operand_forward_unit;

   localparam int XLEN = 32;
   localparam int NSRC = 2;
   localparam int AW   = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset, flush, id_valid;
   logic [NSRC*AW-1:0]   id_rs_addr;
   logic [NSRC-1:0]      id_rs_used;
   logic [NSRC*XLEN-1:0] id_rs_data;
   logic                 ex_valid, ex_wen, ex_is_load, ex_is_link;
   logic [AW-1:0]        ex_rd;
   logic [XLEN-1:0]      ex_alu, ex_pc4;
   logic                 mem_valid, mem_wen, mem_is_load, mem_is_link;
   logic [AW-1:0]        mem_rd;
   logic [XLEN-1:0]      mem_alu, mem_rdata, mem_pc4;
   logic                 wb_valid, wb_wen;
   logic [AW-1:0]        wb_rd;
   logic [XLEN-1:0]      wb_data;

   logic                 stall1, stall3, v1, v3;
   logic [NSRC*XLEN-1:0] opnd1, opnd3;
   logic [NSRC*2-1:0]    src1, src3;

   operand_forward_unit #(.XLEN(XLEN), .NSRC(NSRC), .REG_AW(AW), .LOAD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rs_data(id_rs_data),
      .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_is_link(ex_is_link),
      .ex_rd(ex_rd), .ex_alu(ex_alu), .ex_pc4(ex_pc4),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_is_link(mem_is_link),
      .mem_rd(mem_rd), .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
      .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall1), .opnd(opnd1), .opnd_src(src1), .opnd_valid(v1));

   operand_forward_unit #(.XLEN(XLEN), .NSRC(NSRC), .REG_AW(AW), .LOAD_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rs_data(id_rs_data),
      .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_is_link(ex_is_link),
      .ex_rd(ex_rd), .ex_alu(ex_alu), .ex_pc4(ex_pc4),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .mem_is_link(mem_is_link),
      .mem_rd(mem_rd), .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
      .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall3), .opnd(opnd3), .opnd_src(src3), .opnd_valid(v3));

   int tests = 0;
   int fails = 0;

   // Reference state per instance: index 0 -> LOAD_LAT=1, index 1 -> LOAD_LAT=3.
   int                   lat [2] = '{1, 3};
   int                   left[2] = '{0, 0};
   logic [NSRC*XLEN-1:0] exp_opnd[2];
   logic [NSRC*2-1:0]    exp_src [2];
   logic                 exp_v   [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Youngest producer of the register wins; x0 and unused operands use RF.
   task automatic resolve(input int i, output logic [XLEN-1:0] d, output logic [1:0] s,
                          output bit ld);
      logic [AW-1:0] rs;
      rs = id_rs_addr[i*AW +: AW];
      d  = id_rs_data[i*XLEN +: XLEN];
      s  = 2'd0;
      ld = 1'b0;
      if (id_valid && id_rs_used[i] && rs != 0) begin
         if (ex_valid && ex_wen && ex_rd == rs) begin
            s = 2'd1; d = ex_is_link ? ex_pc4 : ex_alu; ld = ex_is_load;
         end else if (mem_valid && mem_wen && mem_rd == rs) begin
            s = 2'd2;
            d = mem_is_load ? mem_rdata : (mem_is_link ? mem_pc4 : mem_alu);
         end else if (wb_valid && wb_wen && wb_rd == rs) begin
            s = 2'd3; d = wb_data;
         end
      end
   endtask

   // One clock: check combinational stall, clock, check registered outputs.
   task automatic step(input string tag);
      logic [NSRC*XLEN-1:0] ro;
      logic [NSRC*2-1:0]    rsrc;
      logic [XLEN-1:0]      d;
      logic [1:0]           s;
      bit                   ld, hz;
      bit                   es;
      hz = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         resolve(i, d, s, ld);
         ro[i*XLEN +: XLEN] = d;
         rsrc[i*2 +: 2]     = s;
         if (ld) hz = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         es = !reset && !flush && (left[k] > 0 || hz);
         check({tag, (k == 0) ? ".stall_l1" : ".stall_l3"}, (k == 0) ? stall1 : stall3, es);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            exp_opnd[k] = '0; exp_src[k] = '0; exp_v[k] = 1'b0; left[k] = 0;
         end else if (flush) begin
            exp_v[k] = 1'b0; left[k] = 0;
         end else if (left[k] > 0) begin
            exp_v[k] = 1'b0; left[k]--;
         end else if (hz) begin
            exp_v[k] = 1'b0; left[k] = lat[k] - 1;
         end else begin
            exp_opnd[k] = ro; exp_src[k] = rsrc; exp_v[k] = id_valid;
         end
      end
      #1;
      check({tag, ".opnd_l1"},  opnd1, exp_opnd[0]);
      check({tag, ".src_l1"},   src1,  exp_src[0]);
      check({tag, ".valid_l1"}, v1,    exp_v[0]);
      check({tag, ".opnd_l3"},  opnd3, exp_opnd[1]);
      check({tag, ".src_l3"},   src3,  exp_src[1]);
      check({tag, ".valid_l3"}, v3,    exp_v[1]);
      $display("[TB] step %-12s stall1=%b stall3=%b v1=%b v3=%b opnd1=%h opnd3=%h",
               tag, stall1, stall3, v1, v3, opnd1, opnd3);
   endtask

   task automatic clear_inputs();
      flush = 0; id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rs_data = '0;
      ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_is_link = 0; ex_rd = '0;
      ex_alu = '0; ex_pc4 = '0;
      mem_valid = 0; mem_wen = 0; mem_is_load = 0; mem_is_link = 0; mem_rd = '0;
      mem_alu = '0; mem_rdata = '0; mem_pc4 = '0;
      wb_valid = 0; wb_wen = 0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic load_in_ex(input logic [AW-1:0] rd);
      ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_is_link = 0; ex_rd = rd;
      ex_alu = 32'h0000_8000;
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      id_rs_data = {32'h5555_5555, 32'hAAAA_AAAA};
      step("reset0");
      step("reset1");
      check("reset.opnd", opnd1, 64'h0);
      reset = 0;

      // RAW on EX ALU result
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd5};
      ex_valid = 1; ex_wen = 1; ex_rd = 5'd5; ex_alu = 32'h0000_1234;
      step("raw_alu");
      check("raw_alu.opnd0", opnd1[31:0], 32'h0000_1234);
      check("raw_alu.src0",  src1[1:0],   2'd1);

      // Triple match on rs2, then with EX not writing
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b10; id_rs_addr = {5'd7, 5'd0};
      ex_valid = 1;  ex_wen = 1;  ex_rd = 5'd7;  ex_alu = 32'hA;
      mem_valid = 1; mem_wen = 1; mem_rd = 5'd7; mem_alu = 32'hB;
      wb_valid = 1;  wb_wen = 1;  wb_rd = 5'd7;  wb_data = 32'hC;
      step("triple");
      check("triple.opnd1", opnd1[63:32], 32'hA);
      check("triple.src1",  src1[3:2],    2'd1);
      ex_wen = 0;
      step("triple_nex");
      check("triple_nex.opnd1", opnd1[63:32], 32'hB);
      check("triple_nex.src1",  src1[3:2],    2'd2);

      // Load-use: detection, then the load arrives in MEM
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd3};
      load_in_ex(5'd3);
      step("lu_detect");
      check("lu_detect.valid_l1", v1, 1'b0);
      ex_valid = 0; ex_wen = 0; ex_is_load = 0;
      mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_rd = 5'd3; mem_rdata = 32'hDEAD_BEEF;
      step("lu_mem");
      check("lu_mem.opnd0_l1", opnd1[31:0], 32'hDEAD_BEEF);
      check("lu_mem.src0_l1",  src1[1:0],   2'd2);
      check("lu_mem.valid_l3", v3, 1'b0);
      step("lu_l3_c3");
      check("lu_l3_c3.valid_l3", v3, 1'b0);
      step("lu_l3_done");
      check("lu_l3_done.opnd0_l3", opnd3[31:0], 32'hDEAD_BEEF);
      check("lu_l3_done.valid_l3", v3, 1'b1);

      // Reset on the second stall cycle of the LOAD_LAT=3 instance
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd3};
      load_in_ex(5'd3);
      step("rst_detect");
      ex_valid = 0; ex_wen = 0; ex_is_load = 0;
      reset = 1;
      step("rst_mid");
      check("rst_mid.opnd_l3",  opnd3, 64'h0);
      check("rst_mid.valid_l3", v3, 1'b0);
      reset = 0;

      // Link from MEM, then x0 never forwarded
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd1};
      mem_valid = 1; mem_wen = 1; mem_is_link = 1; mem_rd = 5'd1;
      mem_pc4 = 32'h0000_0104; mem_alu = 32'h0000_0999;
      step("link_mem");
      check("link_mem.opnd0", opnd1[31:0], 32'h0000_0104);
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b01; id_rs_addr = '0;
      ex_valid = 1; ex_wen = 1; ex_rd = 5'd0; ex_alu = 32'hFFFF_FFFF;
      step("x0");
      check("x0.opnd0", opnd1[31:0], 32'h0);
      check("x0.src0",  src1[1:0],   2'd0);

      // Flush during a load-use hazard: no stall, bubble, still RUN
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b01; id_rs_addr = {5'd0, 5'd3};
      load_in_ex(5'd3);
      flush = 1;
      step("flush_hz");
      check("flush_hz.valid_l3", v3, 1'b0);
      clear_inputs();
      id_valid = 1; id_rs_used = 2'b11; id_rs_addr = {5'd4, 5'd4};
      id_rs_data = {32'h1111_1111, 32'h2222_2222};
      wb_valid = 1; wb_wen = 1; wb_rd = 5'd4; wb_data = 32'h0BAD_F00D;
      step("after_flush");
      check("after_flush.valid_l3", v3, 1'b1);
      check("after_flush.same_reg", opnd3, {32'h0BAD_F00D, 32'h0BAD_F00D});

      // Random traffic over a small register window to provoke matches
      for (int n = 0; n < 400; n++) begin
         reset      = ($urandom_range(0, 63) == 0);
         flush      = ($urandom_range(0, 7) == 0);
         id_valid   = ($urandom_range(0, 4) != 0);
         id_rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         id_rs_used = 2'($urandom);
         id_rs_data = {$urandom, $urandom};
         ex_valid = 1'($urandom); ex_wen = 1'($urandom);
         ex_is_load = ($urandom_range(0, 3) == 0); ex_is_link = ($urandom_range(0, 3) == 0);
         ex_rd = 5'($urandom_range(0, 7)); ex_alu = $urandom; ex_pc4 = $urandom;
         mem_valid = 1'($urandom); mem_wen = 1'($urandom);
         mem_is_load = 1'($urandom); mem_is_link = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 7));
         mem_alu = $urandom; mem_rdata = $urandom; mem_pc4 = $urandom;
         wb_valid = 1'($urandom); wb_wen = 1'($urandom);
         wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
         step("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
